// File: rtl/if_fetch_queue_pkg.sv
// Shared types for the fetch queue: pc reset value, FSM states, queue entry.
package if_fetch_queue_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] PC_START = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_DRAIN
    } ifq_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Small synchronous FIFO of {pc, inst} entries; flush beats push.
module if_fetch_queue_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Credit accounting upstream must make an overflowing push impossible.
    assert property (@(posedge clk) disable iff (rst || flush)
        !(push && (count == FULL) && !do_pop));

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: credit-limited imem requests, response queue, redirect drain.
// Optional IFQ_PERF_EN adds issue and decode-starvation counters.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = PC_START
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_inst,
`ifdef IFQ_PERF_EN
    output logic [63:0]     perf_fetch_cnt,
    output logic [63:0]     perf_stall_cnt,
`endif
    input  logic            out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT = (CW+1)'(DEPTH);

    ifq_state_e      state;
    ifq_state_e      state_n;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_n;
    logic [CW-1:0]   count;
    logic            issue;
    logic            rsp;
    logic            push;
    logic            pop;
    logic            dropping;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    // Dropped in-flight fetches still hold a credit until they return.
    assign imem_req  = (state != S_BOOT)
                    && (({1'b0, count} + {1'b0, outstanding}) < CREDIT);
    assign imem_addr = fetch_pc;
    assign issue     = imem_req && imem_gnt;
    assign rsp       = imem_rvalid;
    assign dropping  = drop_cnt != '0;
    assign push      = rsp && !dropping && !redirect_valid;
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;
    assign wr_entry  = '{pc: resp_pc, inst: imem_rdata};

    always_comb begin
        drop_n = drop_cnt;
        if (redirect_valid) begin
            drop_n = outstanding + CW'(issue) - CW'(rsp);
        end else if (rsp && dropping) begin
            drop_n = drop_cnt - CW'(1);
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_BOOT:          state_n = S_RUN;
            S_RUN, S_DRAIN:  state_n = (drop_n != '0) ? S_DRAIN : S_RUN;
            default:         state_n = S_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_BOOT;
            fetch_pc    <= PC_RESET;
            resp_pc     <= PC_RESET;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_n;
            drop_cnt    <= drop_n;
            outstanding <= outstanding + CW'(issue) - CW'(rsp);
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 64'd4;
                if (push)  resp_pc  <= resp_pc + 64'd4;
            end
        end
    end

    if_fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (head),
        .count (count)
    );

`ifdef IFQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (issue) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (out_ready && !out_valid) perf_stall_cnt <= perf_stall_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: memory model, epoch-tagged scoreboard, redirect table.
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
`ifdef IFQ_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    if_fetch_queue #(
        .DEPTH    (4),
        .PC_RESET (PC_START)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
`ifdef IFQ_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .out_ready      (out_ready)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
        int          epoch;
    } req_t;

    typedef struct {
        logic [63:0] rpc;
        int          lat;
        int          pre;
        int          gnt;
        int          rdy;
        logic [63:0] exp_first;
    } vec_t;

    exp_t sb[$];
    req_t pipe[$];
    vec_t tbl[5];

    int total, bad;
    int gnt_mode, rdy_mode, lat, issue_budget;
    int cyc, epoch;
    int n_issue, n_pop;
    logic [63:0] exp_fetch;
    logic [63:0] first_issue_addr;
    logic [63:0] first_pop_pc;
    bit want_first_pop;

    function automatic logic [31:0] img(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called at a falling edge: sample, drive next inputs, update model, advance.
    task automatic step(input bit redir, input logic [63:0] rpc);
        logic        s_req, s_ov;
        logic [63:0] s_addr, s_pc;
        logic [31:0] s_inst;
        bit          g, r;
        req_t        h;
        exp_t        e;
        s_req  = imem_req;
        s_addr = imem_addr;
        s_ov   = out_valid;
        s_pc   = out_pc;
        s_inst = out_inst;
        case (gnt_mode)
            0:       g = 1'b0;
            1:       g = 1'b1;
            default: g = ($urandom_range(0, 3) != 0);
        endcase
        if (issue_budget == 0) g = 1'b0;
        case (rdy_mode)
            0:       r = 1'b0;
            1:       r = 1'b1;
            2:       r = s_ov;
            default: r = ($urandom_range(0, 1) != 0);
        endcase
        imem_gnt       = g;
        out_ready      = r;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        if (pipe.size() != 0 && pipe[0].due <= cyc) begin
            h           = pipe.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = img(h.addr);
            if (!redir && h.epoch == epoch) begin
                e.pc   = h.addr;
                e.inst = img(h.addr);
                sb.push_back(e);
            end
        end
        if (s_req && g) begin
            check("issue_addr", s_addr, exp_fetch);
            h.addr  = exp_fetch;
            h.due   = cyc + lat;
            h.epoch = epoch;
            pipe.push_back(h);
            if (n_issue == 0) first_issue_addr = s_addr;
            exp_fetch += 64'd4;
            n_issue++;
            if (issue_budget > 0) issue_budget--;
        end
        if (r && s_ov) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop actual=%h required=none", s_pc);
            end else begin
                e = sb.pop_front();
                check("pop_pc", s_pc, e.pc);
                check("pop_inst", {32'b0, s_inst}, {32'b0, e.inst});
            end
            if (want_first_pop) begin
                first_pop_pc   = s_pc;
                want_first_pop = 1'b0;
            end
            n_pop++;
        end
        if (redir) begin
            epoch++;
            exp_fetch      = rpc;
            sb.delete();
            want_first_pop = 1'b1;
            first_pop_pc   = '0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hdead_beef;
        out_ready      = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_req", {63'b0, imem_req}, 64'd0);
        check("rst_addr", imem_addr, PC_START);
        check("rst_valid", {63'b0, out_valid}, 64'd0);
        check("rst_pc", out_pc, 64'd0);
        check("rst_inst", {32'b0, out_inst}, 64'd0);
`ifdef IFQ_PERF_EN
        check("rst_perf_fetch", perf_fetch_cnt, 64'd0);
        check("rst_perf_stall", perf_stall_cnt, 64'd0);
`endif
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        check("boot_req", {63'b0, imem_req}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("run_req", {63'b0, imem_req}, 64'd1);
        check("run_addr", imem_addr, PC_START);
        pipe.delete();
        sb.delete();
        epoch++;
        exp_fetch      = PC_START;
        cyc            = 0;
        want_first_pop = 1'b0;
    endtask

    task automatic drain();
        gnt_mode = 0;
        rdy_mode = 1;
        for (int i = 0; i < 200 && (pipe.size() != 0 || sb.size() != 0); i++) begin
            step(1'b0, '0);
        end
        check("drain_done", 64'(pipe.size() + sb.size()), 64'd0);
        step(1'b0, '0);
        check("idle_valid", {63'b0, out_valid}, 64'd0);
    endtask

    initial begin
        tbl[0] = '{64'h0000_0000_8000_1000, 3, 2, 1, 1, 64'h0000_0000_8000_1000};
        tbl[1] = '{64'h0000_0000_8000_2000, 2, 3, 1, 1, 64'h0000_0000_8000_2000};
        tbl[2] = '{64'h0000_0000_8000_3000, 1, 6, 1, 0, 64'h0000_0000_8000_3000};
        tbl[3] = '{64'hffff_ffff_ffff_fff8, 2, 5, 2, 3, 64'hffff_ffff_ffff_fff8};
        tbl[4] = '{64'h0000_0000_8000_4000, 4, 4, 1, 2, 64'h0000_0000_8000_4000};

        total = 0;
        bad = 0;
        epoch = 0;
        lat = 1;
        gnt_mode = 0;
        rdy_mode = 0;
        issue_budget = -1;
        n_issue = 0;
        n_pop = 0;
        first_issue_addr = '0;
        first_pop_pc = '0;

        do_reset();
        gnt_mode = 1;
        rdy_mode = 1;
        lat = 1;
        n_pop = 0;
        repeat (12) step(1'b0, '0);
        check("stream_pops", 64'(n_pop), 64'd10);
        drain();

        do_reset();
        gnt_mode = 1;
        rdy_mode = 0;
        n_issue = 0;
        repeat (10) step(1'b0, '0);
        check("full_issues", 64'(n_issue), 64'd4);
        check("full_req_off", {63'b0, imem_req}, 64'd0);
        rdy_mode = 1;
        n_issue = 0;
        n_pop = 0;
        repeat (4) step(1'b0, '0);
        check("full_pops", 64'(n_pop), 64'd4);
        check("resume_addr", first_issue_addr, 64'h0000_0000_8000_0010);
        drain();

        for (int k = 0; k < 5; k++) begin
            lat = tbl[k].lat;
            gnt_mode = tbl[k].gnt;
            rdy_mode = tbl[k].rdy;
            repeat (tbl[k].pre) step(1'b0, '0);
            step(1'b1, tbl[k].rpc);
            gnt_mode = 1;
            rdy_mode = 1;
            for (int i = 0; i < 40 && want_first_pop; i++) step(1'b0, '0);
            check("redirect_first_pc", first_pop_pc, tbl[k].exp_first);
            repeat (8) step(1'b0, '0);
            drain();
        end

        lat = 5;
        gnt_mode = 1;
        rdy_mode = 1;
        repeat (3) step(1'b0, '0);
        step(1'b1, 64'h0000_0000_8000_5000);
        step(1'b0, '0);
        step(1'b1, 64'h0000_0000_8000_6000);
        for (int i = 0; i < 40 && want_first_pop; i++) step(1'b0, '0);
        check("double_redirect_pc", first_pop_pc, 64'h0000_0000_8000_6000);
        repeat (6) step(1'b0, '0);

        lat = 3;
        repeat (3) step(1'b0, '0);
        do_reset();
        gnt_mode = 0;
        rdy_mode = 1;
        repeat (3) step(1'b0, '0);
        gnt_mode = 1;
        rdy_mode = 2;
        lat = 1;
        issue_budget = 10;
        n_issue = 0;
        for (int i = 0; i < 60 && issue_budget != 0; i++) step(1'b0, '0);
        check("perf_issues_seen", 64'(n_issue), 64'd10);
`ifdef IFQ_PERF_EN
        check("perf_fetch_cnt", perf_fetch_cnt, 64'd10);
        check("perf_stall_cnt", perf_stall_cnt, 64'd3);
`endif
        issue_budget = -1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
